stack_ctrl: RTL and testbench

Parametrised LIFO stack with depth tracking, full/empty flags and overflow/underflow reporting. It is the successor to the plain circular stack. A compile-time mode selects circular behaviour (overwrite oldest on full) or saturating behaviour (reject push on full). Used as a return-address or operand stack by small soft cores and control FSMs.

---
 rtl/stack_ctrl.sv | 59 +++++
 tb/tb_stack_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: parametrised LIFO stack with count/flags, overflow/underflow pulses; STACK_CTRL_PEEK_EN adds a registered peek port
module stack_ctrl #(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 4,
  parameter int WRAP       = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
`ifdef STACK_CTRL_PEEK_EN
  input  logic [DEPTH_LOG2-1:0] i_peek_idx,
  output logic [WIDTH-1:0]      o_peek_data,
`endif
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_ovf,
  output logic                  o_unf
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] depth_c = (DEPTH_LOG2+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr, tos, wr_addr;
  logic do_pop, do_push, wr_en;
  assign tos     = ptr - 1'b1;
  assign o_empty = o_count == '0;
  assign o_full  = o_count == depth_c;
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && !do_pop;
  assign wr_en   = i_push && (do_pop || !o_full || WRAP != 0);
  assign wr_addr = do_pop ? tos : ptr;
  always_ff @(posedge i_clk)
    if (!i_rst && wr_en) mem[wr_addr] <= i_data;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr     <= '0;
      o_count <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      o_unf   <= 1'b0;
    end else begin
      ptr     <= (do_pop && !i_push) ? tos : (do_push && (!o_full || WRAP != 0)) ? ptr + 1'b1 : ptr;
      o_count <= (do_pop && !i_push) ? o_count - 1'b1 : (do_push && !o_full) ? o_count + 1'b1 : o_count;
      o_data  <= do_pop ? mem[tos] : o_data;
      o_valid <= do_pop;
      o_ovf   <= i_push && !i_pop && o_full;
      o_unf   <= i_pop && o_empty;
    end
  end
`ifdef STACK_CTRL_PEEK_EN
  always_ff @(posedge i_clk)
    o_peek_data <= i_rst ? '0 : mem[tos - i_peek_idx];
`endif
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: scoreboard bench driving a circular and a saturating stack side by side
module tb_stack_ctrl;
  logic clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] d1, d0;
  logic v1, v0, e1, e0, f1, f0, ov1, ov0, un1, un0;
  logic [2:0] c1, c0;
  int errors = 0, checks = 0;
  logic [7:0] q1[$], q0[$];
`ifdef STACK_CTRL_PEEK_EN
  logic [1:0] peek_idx = '0;
  logic [7:0] pk1, pk0;
`endif
  always #5 clk = ~clk;
  stack_ctrl #(.WIDTH(8), .DEPTH_LOG2(2), .WRAP(1)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_data(data),
`ifdef STACK_CTRL_PEEK_EN
    .i_peek_idx(peek_idx), .o_peek_data(pk1),
`endif
    .o_data(d1), .o_valid(v1), .o_count(c1), .o_empty(e1), .o_full(f1), .o_ovf(ov1), .o_unf(un1));
  stack_ctrl #(.WIDTH(8), .DEPTH_LOG2(2), .WRAP(0)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_data(data),
`ifdef STACK_CTRL_PEEK_EN
    .i_peek_idx(peek_idx), .o_peek_data(pk0),
`endif
    .o_data(d0), .o_valid(v0), .o_count(c0), .o_empty(e0), .o_full(f0), .o_ovf(ov0), .o_unf(un0));
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    push = p;
    pop  = q;
    data = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask
  task automatic exp(input logic [7:0] a, input logic [7:0] b);
    q1.push_back(a);
    q0.push_back(b);
  endtask
  task automatic both(input string n, input int a1, input int a0, input int e);
    chk({n, "_wrap"}, a1, e);
    chk({n, "_sat"}, a0, e);
  endtask
  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      if (q1.size() == 0) chk("wrap_unexpected_valid", 1, 0);
      else chk("wrap_pop_data", int'(d1), int'(q1.pop_front()));
    end
    if (v0 === 1'b1) begin
      if (q0.size() == 0) chk("sat_unexpected_valid", 1, 0);
      else chk("sat_pop_data", int'(d0), int'(q0.pop_front()));
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    both("rst_count", c1, c0, 0);
    both("rst_empty", e1, e0, 1);
    both("rst_valid", v1, v0, 0);
    both("rst_data", d1, d0, 0);
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
    both("t1_count", c1, c0, 3);
    both("t1_empty", e1, e0, 0);
    both("t1_full", f1, f0, 0);
    exp(8'h33, 8'h33); exp(8'h22, 8'h22); exp(8'h11, 8'h11);
    step(0, 1, 0);
    both("t1_valid_lat", v1, v0, 1);
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
    both("t1_valid_clr", v1, v0, 0);
    both("t1_end_count", c1, c0, 0);
    both("t1_end_empty", e1, e0, 1);
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
    both("t2_full", f1, f0, 1);
    step(1, 0, 8'h05);
    both("t2_ovf", ov1, ov0, 1);
    both("t2_count", c1, c0, 4);
    step(0, 0, 0);
    both("t2_ovf_clr", ov1, ov0, 0);
    exp(8'h05, 8'h04); exp(8'h04, 8'h03); exp(8'h03, 8'h02); exp(8'h02, 8'h01);
    repeat (4) step(0, 1, 0);
    step(0, 0, 0);
    both("t2_end_count", c1, c0, 0);
    exp(8'hAA, 8'hAA);
    step(1, 0, 8'hAA);
    step(1, 1, 8'hBB);
    both("t4_valid", v1, v0, 1);
    both("t4_count", c1, c0, 1);
    both("t4_no_ovf", ov1, ov0, 0);
    exp(8'hBB, 8'hBB);
    step(0, 1, 0);
    both("t4_end_count", c1, c0, 0);
    step(0, 1, 0);
    both("t5_unf", un1, un0, 1);
    both("t5_valid", v1, v0, 0);
    both("t5_count", c1, c0, 0);
    step(1, 1, 8'h5C);
    both("t5_pp_unf", un1, un0, 1);
    both("t5_pp_valid", v1, v0, 0);
    both("t5_pp_count", c1, c0, 1);
    exp(8'h5C, 8'h5C);
    step(0, 1, 0);
    step(0, 0, 0);
    both("t5_unf_clr", un1, un0, 0);
    step(1, 0, 8'h10); step(1, 0, 8'h20);
    rst = 1'b1;
    step(0, 1, 0);
    rst = 1'b0;
    both("t6_count", c1, c0, 0);
    both("t6_data", d1, d0, 0);
    both("t6_valid", v1, v0, 0);
`ifdef STACK_CTRL_PEEK_EN
    step(1, 0, 8'h10); step(1, 0, 8'h20); step(1, 0, 8'h30);
    peek_idx = 2'd2;
    step(0, 0, 0);
    both("t6_peek", pk1, pk0, 8'h10);
`endif
    repeat (2) step(0, 0, 0);
    chk("wrap_queue_drained", q1.size(), 0);
    chk("sat_queue_drained", q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
